reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of ROB entries; TAG_W, default 4, ROB tag width, equal to log2(DEPTH).
REQ-002 SHALL have ports (name direction width meaning), in this order:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  dispatch requests an entry
alloc_ready  out  1  entry can be accepted this cycle
alloc_tag  out  TAG_W  tag assigned to the allocating instruction (the tail index)
alloc_rd_log  in  5  logical destination
alloc_rd_phys  in  6  new physical destination
alloc_rd_old_phys  in  6  stale physical register to free at commit
alloc_reg_write  in  1  instruction writes rd
alloc_is_branch  in  1  branch/jump
alloc_pc  in  32  instruction PC
wb_valid  in  1  execution-complete broadcast
wb_tag  in  TAG_W  ROB tag of the completing instruction
wb_mispredict  in  1  completing branch mispredicted
commit_valid  out  1  head retires this cycle
commit_rd_log  out  5  head logical destination
commit_rd_phys  out  6  head new physical register
commit_rd_old_phys  out  6  physical register to return to the free list
commit_reg_write  out  1  head writes rd
flush_valid  out  1  one-cycle pipeline flush
flush_pc  out  32  PC of the mispredicted branch
count  out  TAG_W+1  occupied entries, 0..DEPTH
empty  out  1  count==0

Function
REQ-003 SHALL store per entry: valid, done, rd_log, rd_phys, rd_old_phys, reg_write, is_branch, mispredicted, pc.
REQ-004 SHALL keep head and tail pointers (TAG_W bits) that wrap naturally from DEPTH-1 to 0, plus a count register.
REQ-005 SHALL implement two states: RUN and FLUSH. RUN goes to FLUSH on a mispredicted commit. FLUSH returns to RUN unconditionally after one cycle.
REQ-006 SHALL drive alloc_ready = (state==RUN) && (count<DEPTH) && !(commit of a mispredicted branch this cycle). No bypass: when full, a same-cycle commit does not free a slot for allocation.
REQ-007 SHALL drive alloc_tag = tail at all times.
REQ-008 SHALL perform an allocation on alloc_valid && alloc_ready: write the entry at tail with valid=1, done=0, mispredicted=0, then advance tail by 1.
REQ-009 SHALL process wb_valid when entry[wb_tag].valid: set done=1 and set mispredicted to wb_mispredict. A writeback to an invalid entry is ignored.
REQ-010 SHALL drive commit_valid = (state==RUN) && entry[head].valid && entry[head].done, combinationally, with commit_* fields taken from entry[head].
REQ-011 SHALL retire on commit_valid: clear entry[head].valid and advance head by 1.
REQ-012 SHALL treat a same-cycle writeback to the head entry as visible the next cycle only; there is no writeback-to-commit bypass.
REQ-013 SHALL update count by +1 on allocate, -1 on commit, and leave it unchanged when both occur in the same cycle.
REQ-014 SHALL handle a mispredicted commit (commit_valid && head is_branch && head mispredicted) as follows:
- the branch itself still commits that cycle;
- at the clock edge, clear all valid bits, set head=tail=0 and count=0, and register flush_pc = head pc;
- enter FLUSH.
REQ-015 SHALL assert flush_valid only in FLUSH, for exactly one cycle. During FLUSH, alloc_ready=0 and commit_valid=0, and writebacks are ignored.
REQ-016 SHALL drive empty = (count==0).

Reset
REQ-017 SHALL, on rst_n low (asynchronous), clear all valid/done/mispredicted bits, set head=tail=count=0, state=RUN, and flush_pc=0.
REQ-018 SHALL produce these output values during and after reset: alloc_ready=1 (after release), alloc_tag=0, commit_valid=0, flush_valid=0, count=0, empty=1.
REQ-019 SHALL, on reset asserted mid-operation, discard all in-flight entries with no commit or flush emitted.

Verification
REQ-020 In-order retire: allocate tags 0,1,2; writeback 2 then 0 then 1 -> commit of tag 0 appears the cycle after wb 0, tag 1 the cycle after wb 1, tag 2 the following cycle; commit_rd_old_phys matches the allocated values.
REQ-021 Full: 16 allocations with no writeback -> count=16, alloc_ready=0. Writeback tag 0 -> one commit; alloc_ready=1 the next cycle, and the 17th allocation receives alloc_tag=0 (wrap-around).
REQ-022 Simultaneous events: at count=5, allocate and commit in the same cycle -> count stays 5, head and tail each advance by 1.
REQ-023 Mispredict: allocate a branch at pc=0x40 (tag 0) plus tags 1 and 2; wb tag 0 with mispredict=1 -> tag 0 commits, then next cycle flush_valid=1 with flush_pc=0x40, count=0, alloc_ready=0; the cycle after, alloc_ready=1 and alloc_tag=0.
REQ-024 Stale writeback: wb_valid to an unallocated tag 7 while empty -> no state change, commit_valid stays 0.
REQ-025 Reset mid-operation: with 3 entries valid and done, pull rst_n low -> commit_valid=0 and count=0 immediately, and no commit appears after release.

Source files
------------

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retire reorder buffer with mispredict flush
//
// Parameters: DEPTH entries, TAG_W = log2(DEPTH) tag bits.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   alloc_valid/alloc_ready        dispatch handshake; alloc_tag is the tail index
//   alloc_rd_log/rd_phys/rd_old_phys/reg_write/is_branch/pc  entry payload
//   wb_valid, wb_tag, wb_mispredict  execution-complete broadcast
//   commit_valid, commit_rd_*      head retirement (combinational from head entry)
//   flush_valid, flush_pc          one-cycle flush after a mispredicted commit
//   count, empty                   occupancy
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [4:0]       alloc_rd_log,
    input  logic [5:0]       alloc_rd_phys,
    input  logic [5:0]       alloc_rd_old_phys,
    input  logic             alloc_reg_write,
    input  logic             alloc_is_branch,
    input  logic [31:0]      alloc_pc,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             wb_mispredict,
    output logic             commit_valid,
    output logic [4:0]       commit_rd_log,
    output logic [5:0]       commit_rd_phys,
    output logic [5:0]       commit_rd_old_phys,
    output logic             commit_reg_write,
    output logic             flush_valid,
    output logic [31:0]      flush_pc,
    output logic [TAG_W:0]   count,
    output logic             empty
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [TAG_W:0]   DEPTH_C = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] PTR_ONE = 1;
    localparam logic [TAG_W:0]   CNT_ONE = 1;

    state_t           state;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic             flush_q;

    // Control bits are reset; payload is qualified by valid and needs no reset.
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] mispred;

    logic [4:0]  rd_log_mem     [DEPTH];
    logic [5:0]  rd_phys_mem    [DEPTH];
    logic [5:0]  rd_old_phys_mem[DEPTH];
    logic        reg_write_mem  [DEPTH];
    logic        is_branch_mem  [DEPTH];
    logic [31:0] pc_mem         [DEPTH];

    logic mispred_commit;
    logic alloc_fire;

    assign commit_valid   = (state == RUN) && valid[head] && done[head];
    assign mispred_commit = commit_valid && is_branch_mem[head] && mispred[head];
    // A retiring entry does not free a slot for same-cycle allocation.
    assign alloc_ready    = (state == RUN) && (count < DEPTH_C) && !mispred_commit;
    assign alloc_fire     = alloc_valid && alloc_ready;
    assign alloc_tag      = tail;

    assign commit_rd_log      = rd_log_mem[head];
    assign commit_rd_phys     = rd_phys_mem[head];
    assign commit_rd_old_phys = rd_old_phys_mem[head];
    assign commit_reg_write   = reg_write_mem[head];

    assign flush_valid = flush_q;
    assign empty       = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            valid    <= '0;
            done     <= '0;
            mispred  <= '0;
            flush_pc <= '0;
            flush_q  <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                RUN: begin
                    if (mispred_commit) begin
                        // The branch retires; everything younger is squashed.
                        valid    <= '0;
                        head     <= '0;
                        tail     <= '0;
                        count    <= '0;
                        flush_pc <= pc_mem[head];
                        flush_q  <= 1'b1;
                        state    <= FLUSH;
                    end else begin
                        if (alloc_fire) begin
                            valid[tail]   <= 1'b1;
                            done[tail]    <= 1'b0;
                            mispred[tail] <= 1'b0;
                            tail          <= tail + PTR_ONE;
                        end
                        // Uses pre-edge valid, so a writeback to the slot being
                        // allocated this cycle is dropped as stale.
                        if (wb_valid && valid[wb_tag]) begin
                            done[wb_tag]    <= 1'b1;
                            mispred[wb_tag] <= wb_mispredict;
                        end
                        if (commit_valid) begin
                            valid[head] <= 1'b0;
                            head        <= head + PTR_ONE;
                        end
                        case ({alloc_fire, commit_valid})
                            2'b10:   count <= count + CNT_ONE;
                            2'b01:   count <= count - CNT_ONE;
                            default: count <= count;
                        endcase
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_log_mem[tail]      <= alloc_rd_log;
            rd_phys_mem[tail]     <= alloc_rd_phys;
            rd_old_phys_mem[tail] <= alloc_rd_old_phys;
            reg_write_mem[tail]   <= alloc_reg_write;
            is_branch_mem[tail]   <= alloc_is_branch;
            pc_mem[tail]          <= alloc_pc;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic [4:0]  alloc_rd_log;
    logic [5:0]  alloc_rd_phys;
    logic [5:0]  alloc_rd_old_phys;
    logic        alloc_reg_write;
    logic        alloc_is_branch;
    logic [31:0] alloc_pc;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic        wb_mispredict;
    logic        commit_valid;
    logic [4:0]  commit_rd_log;
    logic [5:0]  commit_rd_phys;
    logic [5:0]  commit_rd_old_phys;
    logic        commit_reg_write;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [4:0]  count;
    logic        empty;

    reorder_buffer #(.DEPTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_rd_log(alloc_rd_log), .alloc_rd_phys(alloc_rd_phys),
        .alloc_rd_old_phys(alloc_rd_old_phys), .alloc_reg_write(alloc_reg_write),
        .alloc_is_branch(alloc_is_branch), .alloc_pc(alloc_pc),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_mispredict(wb_mispredict),
        .commit_valid(commit_valid), .commit_rd_log(commit_rd_log),
        .commit_rd_phys(commit_rd_phys), .commit_rd_old_phys(commit_rd_old_phys),
        .commit_reg_write(commit_reg_write),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd_log;
        logic [5:0] rd_phys;
        logic [5:0] old_phys;
        logic       reg_write;
    } sb_t;

    typedef struct {
        logic       av;
        logic       wv;
        logic [3:0] wtag;
        logic       wmis;
        logic       exp_cv;
        logic [4:0] exp_cnt;
        logic       exp_ready;
        logic [3:0] exp_tag;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[12];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alloc(input logic br, input logic [31:0] pc);
        sb_t e;
        e.rd_log    = 5'($urandom);
        e.rd_phys   = 6'($urandom);
        e.old_phys  = 6'($urandom);
        e.reg_write = 1'($urandom);
        alloc_valid       = 1'b1;
        alloc_rd_log      = e.rd_log;
        alloc_rd_phys     = e.rd_phys;
        alloc_rd_old_phys = e.old_phys;
        alloc_reg_write   = e.reg_write;
        alloc_is_branch   = br;
        alloc_pc          = pc;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_is_branch = 1'b0; alloc_pc = '0;
        alloc_rd_log = '0; alloc_rd_phys = '0; alloc_rd_old_phys = '0; alloc_reg_write = 1'b0;
        wb_valid = 1'b0; wb_tag = '0; wb_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wb(input logic [3:0] tag, input logic mis);
        wb_valid = 1'b1; wb_tag = tag; wb_mispredict = mis;
        tick();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
    endtask

    // Commit monitor: every retirement must match the oldest outstanding allocation.
    always @(negedge clk) begin
        if (rst_n && commit_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_commit: got commit_valid=1 expected no commit at %0t", $time);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("commit_rd_log", 32'(commit_rd_log), 32'(e.rd_log));
                check("commit_rd_phys", 32'(commit_rd_phys), 32'(e.rd_phys));
                check("commit_rd_old_phys", 32'(commit_rd_old_phys), 32'(e.old_phys));
                check("commit_reg_write", 32'(commit_reg_write), 32'(e.reg_write));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            av  wv  wtag  wmis cv  cnt  rdy tag
        vecs[0]  = '{1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 5'd0, 1'b1, 4'd0}; // stale wb
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd1, 1'b1, 4'd1};
        vecs[4]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd2, 1'b1, 4'd2};
        vecs[5]  = '{1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 5'd3, 1'b1, 4'd3};
        vecs[6]  = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 5'd3, 1'b1, 4'd3};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, 1'b1, 4'd3}; // tag 0 retires
        vecs[8]  = '{1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 5'd2, 1'b1, 4'd3}; // wb to head not yet visible
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd2, 1'b1, 4'd3}; // tag 1 retires
        vecs[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd1, 1'b1, 4'd3}; // tag 2 retires
        vecs[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd3};

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        #12;
        check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_flush_valid", 32'(flush_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);

        // Table: stale writeback, then out-of-order completion with in-order retire
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            if (vecs[i].av) drive_alloc(1'b0, 32'h100 + 32'(i));
            wb_valid      = vecs[i].wv;
            wb_tag        = vecs[i].wtag;
            wb_mispredict = vecs[i].wmis;
            check($sformatf("vec%0d_commit_valid", i), 32'(commit_valid), 32'(vecs[i].exp_cv));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_alloc_tag", i), 32'(alloc_tag), 32'(vecs[i].exp_tag));
            tick();
        end
        idle_inputs();
        check("inorder_all_retired", 32'(sb.size()), 32'd0);

        // Full with no bypass, then wrap-around of the tail
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_alloc(1'b0, 32'(i));
            tick();
        end
        idle_inputs();
        check("full_count", 32'(count), 32'd16);
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        check("full_empty", 32'(empty), 32'd0);
        wb(4'd0, 1'b0);
        check("full_commit_valid", 32'(commit_valid), 32'd1);
        check("full_no_bypass_ready", 32'(alloc_ready), 32'd0);
        tick();
        check("full_after_commit_count", 32'(count), 32'd15);
        check("full_after_commit_ready", 32'(alloc_ready), 32'd1);
        check("wrap_alloc_tag", 32'(alloc_tag), 32'd0);
        drive_alloc(1'b0, 32'h200);
        tick();
        idle_inputs();
        check("wrap_count", 32'(count), 32'd16);
        check("wrap_next_tag", 32'(alloc_tag), 32'd1);

        // Simultaneous allocate and commit at count=5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_alloc(1'b0, 32'(i));
            tick();
        end
        idle_inputs();
        wb(4'd0, 1'b0);
        drive_alloc(1'b0, 32'h300);
        check("simul_commit_valid", 32'(commit_valid), 32'd1);
        check("simul_count_before", 32'(count), 32'd5);
        check("simul_tag_before", 32'(alloc_tag), 32'd5);
        tick();
        idle_inputs();
        check("simul_count_after", 32'(count), 32'd5);
        check("simul_tag_after", 32'(alloc_tag), 32'd6);
        check("simul_head_not_done", 32'(commit_valid), 32'd0);
        wb(4'd1, 1'b0);
        check("simul_head_advanced", 32'(commit_valid), 32'd1);
        tick();
        check("simul_count_drain", 32'(count), 32'd4);

        // Mispredicted branch commit and flush
        do_reset();
        drive_alloc(1'b1, 32'h40);
        tick();
        drive_alloc(1'b0, 32'h44);
        tick();
        drive_alloc(1'b0, 32'h48);
        tick();
        idle_inputs();
        wb(4'd0, 1'b1);
        check("mis_commit_valid", 32'(commit_valid), 32'd1);
        check("mis_alloc_ready", 32'(alloc_ready), 32'd0);
        check("mis_flush_early", 32'(flush_valid), 32'd0);
        tick();
        sb.delete();
        check("mis_flush_valid", 32'(flush_valid), 32'd1);
        check("mis_flush_pc", flush_pc, 32'h40);
        check("mis_count", 32'(count), 32'd0);
        check("mis_flush_ready", 32'(alloc_ready), 32'd0);
        check("mis_flush_commit", 32'(commit_valid), 32'd0);
        tick();
        check("mis_flush_done", 32'(flush_valid), 32'd0);
        check("mis_ready_after", 32'(alloc_ready), 32'd1);
        check("mis_tag_after", 32'(alloc_tag), 32'd0);
        check("mis_empty_after", 32'(empty), 32'd1);

        // Reset mid-operation with three completed entries
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_alloc(1'b0, 32'(i));
            tick();
        end
        idle_inputs();
        wb(4'd1, 1'b0);
        wb(4'd2, 1'b0);
        wb(4'd0, 1'b0);
        check("midrst_ready_to_commit", 32'(commit_valid), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_commit_valid", 32'(commit_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_flush", 32'(flush_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("midrst_after_cv%0d", i), 32'(commit_valid), 32'd0);
        end
        check("midrst_after_ready", 32'(alloc_ready), 32'd1);
        check("midrst_after_tag", 32'(alloc_tag), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
